// File: rtl/writeback_queue.sv
// writeback_queue: ordered write-back buffer between the memory/ALU producers
// and the 8x16 register file write port. One result drains per clock through a
// registered output stage. When the FIFO is empty, a result bypasses straight
// into the output stage.
// Build option: define WB_FORWARD_EN to build the forwarding comparator
// (fwd_hit/fwd_data). Without it, both outputs are tied to zero.
module writeback_queue #(
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        flush,
    input  logic        mem_valid,
    input  logic [2:0]  mem_adr,
    input  logic [15:0] mem_data,
    output logic        mem_ready,
    input  logic        alu_valid,
    input  logic [2:0]  alu_adr,
    input  logic [15:0] alu_data,
    output logic        alu_ready,
    output logic        write_en,
    output logic [2:0]  write_adr,
    output logic [15:0] write_data,
    output logic [3:0]  pending,
    input  logic [2:0]  fwd_adr,
    output logic        fwd_hit,
    output logic [15:0] fwd_data
);
    localparam int            PW       = $clog2(DEPTH);
    localparam logic [3:0]    DEPTH_C  = 4'(DEPTH);
    localparam logic [3:0]    DEPTH_M1 = 4'(DEPTH - 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    // Pointer increment with explicit wrap so non-power-of-2 depths work.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        logic [PW-1:0] r;
        if (p == LAST_PTR) begin
            r = '0;
        end else begin
            r = p + PW'(1);
        end
        return r;
    endfunction

    logic [2:0]    fifo_adr_q  [DEPTH];
    logic [15:0]   fifo_data_q [DEPTH];
    logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
    logic [3:0]    count_q, count_d;
    logic          wen_q, wen_d;
    logic [2:0]    wadr_q, wadr_d;
    logic [15:0]   wdata_q, wdata_d;

    logic          mem_acc_s, alu_acc_s;
    logic          we0_s, we1_s;
    logic [2:0]    e0_adr_s;
    logic [15:0]   e0_data_s;
    logic [PW-1:0] slot1_s;

    // Readiness depends only on the current occupancy. A drain in the same cycle is not credited.
    assign mem_ready = (count_q < DEPTH_C);
    assign alu_ready = (count_q < DEPTH_M1) || ((count_q < DEPTH_C) && !mem_valid);
    assign mem_acc_s = mem_valid && mem_ready;
    assign alu_acc_s = alu_valid && alu_ready;
    assign slot1_s   = ptr_inc(wr_q);

    assign write_en   = wen_q;
    assign write_adr  = wadr_q;
    assign write_data = wdata_q;
    assign pending    = count_q;

    // Candidate list (queue, then mem, then ALU): head goes to the output stage, the rest are stored in order.
    always_comb begin
        rd_d      = rd_q;
        wr_d      = wr_q;
        count_d   = count_q;
        wen_d     = 1'b0;
        wadr_d    = wadr_q;
        wdata_d   = wdata_q;
        we0_s     = 1'b0;
        we1_s     = 1'b0;
        e0_adr_s  = alu_adr;
        e0_data_s = alu_data;
        if (flush) begin
            rd_d    = '0;
            wr_d    = '0;
            count_d = 4'd0;
        end else if (count_q != 4'd0) begin
            wen_d   = 1'b1;
            wadr_d  = fifo_adr_q[rd_q];
            wdata_d = fifo_data_q[rd_q];
            rd_d    = ptr_inc(rd_q);
            if (mem_acc_s && alu_acc_s) begin
                we0_s     = 1'b1;
                we1_s     = 1'b1;
                e0_adr_s  = mem_adr;
                e0_data_s = mem_data;
                wr_d      = ptr_inc(slot1_s);
                count_d   = count_q + 4'd1;
            end else if (mem_acc_s) begin
                we0_s     = 1'b1;
                e0_adr_s  = mem_adr;
                e0_data_s = mem_data;
                wr_d      = slot1_s;
            end else if (alu_acc_s) begin
                we0_s = 1'b1;
                wr_d  = slot1_s;
            end else begin
                count_d = count_q - 4'd1;
            end
        end else if (mem_acc_s) begin
            wen_d   = 1'b1;
            wadr_d  = mem_adr;
            wdata_d = mem_data;
            if (alu_acc_s) begin
                we0_s   = 1'b1;
                wr_d    = slot1_s;
                count_d = 4'd1;
            end else begin
                count_d = count_q;
            end
        end else if (alu_acc_s) begin
            wen_d   = 1'b1;
            wadr_d  = alu_adr;
            wdata_d = alu_data;
        end else begin
            wen_d = 1'b0;
        end
    end

    // FIFO storage: up to two entries are stored per cycle, in program order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                fifo_adr_q[i]  <= 3'd0;
                fifo_data_q[i] <= 16'h0000;
            end
        end else begin
            if (we0_s) begin
                fifo_adr_q[wr_q]  <= e0_adr_s;
                fifo_data_q[wr_q] <= e0_data_s;
            end
            if (we1_s) begin
                fifo_adr_q[slot1_s]  <= alu_adr;
                fifo_data_q[slot1_s] <= alu_data;
            end
        end
    end

    // Pointers, occupancy and the registered register-file write port.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= 4'd0;
            wen_q   <= 1'b0;
            wadr_q  <= 3'd0;
            wdata_q <= 16'h0000;
        end else begin
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
            wen_q   <= wen_d;
            wadr_q  <= wadr_d;
            wdata_q <= wdata_d;
        end
    end

`ifdef WB_FORWARD_EN
    localparam int PW1 = PW + 1;
    logic [PW:0] fwd_slot_s;

    // Scan queued entries oldest to newest so the newest match is the one left standing.
    always_comb begin
        fwd_hit    = 1'b0;
        fwd_data   = 16'h0000;
        fwd_slot_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_slot_s = {1'b0, rd_q} + PW1'(i);
            fwd_slot_s = (fwd_slot_s >= PW1'(DEPTH)) ? (fwd_slot_s - PW1'(DEPTH)) : fwd_slot_s;
            if ((4'(i) < count_q) && (fifo_adr_q[fwd_slot_s[PW-1:0]] == fwd_adr)) begin
                fwd_hit  = 1'b1;
                fwd_data = fifo_data_q[fwd_slot_s[PW-1:0]];
            end else begin
                fwd_hit  = fwd_hit;
                fwd_data = fwd_data;
            end
        end
    end
`else
    logic unused_fwd_s;
    assign unused_fwd_s = ^fwd_adr;
    assign fwd_hit      = 1'b0;
    assign fwd_data     = 16'h0000;
`endif

endmodule

// File: tb/tb_writeback_queue.sv
// Bench for writeback_queue: a directed vector table, an asynchronous reset
// sequence and randomized traffic. All are checked against a queue-based model
// of the candidate-list rules.
module tb_writeback_queue;
    localparam int DEPTH = 4;

    typedef struct {
        logic [2:0]  adr;
        logic [15:0] data;
    } ent_t;

    typedef struct {
        logic        fl;
        logic        mv;
        logic [2:0]  ma;
        logic [15:0] md;
        logic        av;
        logic [2:0]  aa;
        logic [15:0] ad;
        logic [2:0]  fa;
        logic        emr;
        logic        ear;
        logic        efh;
        logic [15:0] efd;
        logic        ew;
        logic [2:0]  ewa;
        logic [15:0] ewd;
        logic [3:0]  ep;
    } vec_t;

    logic        clock, reset_n, flush;
    logic        mem_valid, alu_valid, mem_ready, alu_ready;
    logic [2:0]  mem_adr, alu_adr, write_adr, fwd_adr;
    logic [15:0] mem_data, alu_data, write_data, fwd_data;
    logic        write_en, fwd_hit;
    logic [3:0]  pending;

    int          errors = 0;
    int          checks = 0;
    ent_t        q[$];
    logic        m_wen;
    logic [2:0]  m_wadr;
    logic [15:0] m_wdata;
    logic [15:0] rf [8];
    vec_t        vecs [11];

    writeback_queue #(.DEPTH(DEPTH)) dut (
        .clock(clock), .reset_n(reset_n), .flush(flush),
        .mem_valid(mem_valid), .mem_adr(mem_adr), .mem_data(mem_data), .mem_ready(mem_ready),
        .alu_valid(alu_valid), .alu_adr(alu_adr), .alu_data(alu_data), .alu_ready(alu_ready),
        .write_en(write_en), .write_adr(write_adr), .write_data(write_data),
        .pending(pending), .fwd_adr(fwd_adr), .fwd_hit(fwd_hit), .fwd_data(fwd_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Newest queued entry targeting the address, when forwarding is built.
    task automatic model_fwd(input logic [2:0] a, output logic h, output logic [15:0] d);
        h = 1'b0;
        d = 16'h0000;
`ifdef WB_FORWARD_EN
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].adr == a) begin
                h = 1'b1;
                d = q[i].data;
                break;
            end
        end
`endif
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_write_en"}, write_en, 1'b0);
        chk({tag, "_write_adr"}, write_adr, 3'd0);
        chk({tag, "_write_data"}, write_data, 16'h0000);
        chk({tag, "_pending"}, pending, 4'd0);
        chk({tag, "_mem_ready"}, mem_ready, 1'b1);
        chk({tag, "_alu_ready"}, alu_ready, 1'b1);
        chk({tag, "_fwd_hit"}, fwd_hit, 1'b0);
        chk({tag, "_fwd_data"}, fwd_data, 16'h0000);
    endtask

    // Called 1 time unit after a posedge; drives inputs, checks both sides of the next edge.
    task automatic run_cycle(input vec_t v, input bit use_tab);
        int          c;
        logic        emr, ear, fh, tfh;
        logic [15:0] fd, tfd;
        ent_t        e;
        flush = v.fl; mem_valid = v.mv; mem_adr = v.ma; mem_data = v.md;
        alu_valid = v.av; alu_adr = v.aa; alu_data = v.ad; fwd_adr = v.fa;
        #7;
        c   = q.size();
        emr = (c < DEPTH);
        ear = (c < DEPTH - 1) || ((c < DEPTH) && !v.mv);
        model_fwd(v.fa, fh, fd);
        chk("mem_ready", mem_ready, emr);
        chk("alu_ready", alu_ready, ear);
        chk("fwd_hit", fwd_hit, fh);
        chk("fwd_data", fwd_data, fd);
        if (use_tab) begin
`ifdef WB_FORWARD_EN
            tfh = v.efh; tfd = v.efd;
`else
            tfh = 1'b0;  tfd = 16'h0000;
`endif
            chk("tab_mem_ready", mem_ready, v.emr);
            chk("tab_alu_ready", alu_ready, v.ear);
            chk("tab_fwd_hit", fwd_hit, tfh);
            chk("tab_fwd_data", fwd_data, tfd);
        end
        @(posedge clock);
        if (v.fl) begin
            q.delete();
            m_wen = 1'b0;
        end else begin
            if (v.mv && emr) q.push_back('{adr: v.ma, data: v.md});
            if (v.av && ear) q.push_back('{adr: v.aa, data: v.ad});
            if (q.size() > 0) begin
                e       = q.pop_front();
                m_wen   = 1'b1;
                m_wadr  = e.adr;
                m_wdata = e.data;
            end else begin
                m_wen = 1'b0;
            end
        end
        #1;
        chk("write_en", write_en, m_wen);
        chk("write_adr", write_adr, m_wadr);
        chk("write_data", write_data, m_wdata);
        chk("pending", pending, 32'(q.size()));
        if (write_en === 1'b1) rf[write_adr] = write_data;
        if (use_tab) begin
            chk("tab_write_en", write_en, v.ew);
            chk("tab_write_adr", write_adr, v.ewa);
            chk("tab_write_data", write_data, v.ewd);
            chk("tab_pending", pending, v.ep);
        end
    endtask

    initial begin
        vec_t v;
        reset_n = 1'b0; flush = 1'b0;
        mem_valid = 1'b0; mem_adr = 3'd0; mem_data = 16'h0000;
        alu_valid = 1'b0; alu_adr = 3'd0; alu_data = 16'h0000; fwd_adr = 3'd0;
        m_wen = 1'b0; m_wadr = 3'd0; m_wdata = 16'h0000;
        for (int i = 0; i < 8; i++) rf[i] = 16'h0000;

        //          fl    mv    ma    md         av    aa    ad         fa    emr   ear   efh   efd        ew    ewa   ewd        ep
        vecs[0]  = '{1'b0, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd3, 16'h1234, 3'd0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 3'd3, 16'h1234, 4'd0};
        vecs[1]  = '{1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 3'd0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 3'd3, 16'h1234, 4'd0};
        vecs[2]  = '{1'b0, 1'b1, 3'd2, 16'hAAAA, 1'b1, 3'd2, 16'h5555, 3'd0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 3'd2, 16'hAAAA, 4'd1};
        vecs[3]  = '{1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 3'd2, 1'b1, 1'b1, 1'b1, 16'h5555, 1'b1, 3'd2, 16'h5555, 4'd0};
        vecs[4]  = '{1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 3'd2, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 3'd2, 16'h5555, 4'd0};
        vecs[5]  = '{1'b0, 1'b1, 3'd1, 16'h0101, 1'b1, 3'd4, 16'h0404, 3'd0, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 3'd1, 16'h0101, 4'd1};
        vecs[6]  = '{1'b0, 1'b1, 3'd5, 16'h0011, 1'b1, 3'd5, 16'h0022, 3'd4, 1'b1, 1'b1, 1'b1, 16'h0404, 1'b1, 3'd4, 16'h0404, 4'd2};
        vecs[7]  = '{1'b0, 1'b1, 3'd6, 16'h0606, 1'b1, 3'd7, 16'h0707, 3'd5, 1'b1, 1'b1, 1'b1, 16'h0022, 1'b1, 3'd5, 16'h0011, 4'd3};
        vecs[8]  = '{1'b0, 1'b1, 3'd0, 16'h0F0F, 1'b1, 3'd1, 16'hDEAD, 3'd0, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 3'd5, 16'h0022, 4'd3};
        vecs[9]  = '{1'b1, 1'b0, 3'd0, 16'h0000, 1'b1, 3'd2, 16'hBEEF, 3'd6, 1'b1, 1'b1, 1'b1, 16'h0606, 1'b0, 3'd5, 16'h0022, 4'd0};
        vecs[10] = '{1'b0, 1'b0, 3'd0, 16'h0000, 1'b0, 3'd0, 16'h0000, 3'd6, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 3'd5, 16'h0022, 4'd0};

        #2;
        chk_reset("por");
        #10;
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        for (int i = 0; i < 11; i++) run_cycle(vecs[i], 1'b1);
        chk("rf_r2_last_value", rf[2], 16'h5555);

        // Asynchronous reset between edges with two results pending.
        v = '{1'b0, 1'b1, 3'd1, 16'h1111, 1'b1, 3'd2, 16'h2222, 3'd2,
              1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd0, 16'h0000, 4'd0};
        run_cycle(v, 1'b0);
        v.md = 16'h3333; v.ad = 16'h4444;
        run_cycle(v, 1'b0);
        chk("pending_before_reset", pending, 4'd2);
        mem_valid = 1'b0; alu_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        chk_reset("async");
        q.delete(); m_wen = 1'b0; m_wadr = 3'd0; m_wdata = 16'h0000;
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        v.mv = 1'b0; v.av = 1'b0;
        for (int i = 0; i < 3; i++) run_cycle(v, 1'b0);

        // Randomized two-producer traffic with occasional flushes.
        for (int n = 0; n < 500; n++) begin
            v.fl = ($urandom_range(0, 24) == 0);
            v.mv = ($urandom_range(0, 3) != 0);
            v.ma = 3'($urandom_range(0, 7));
            v.md = 16'($urandom());
            v.av = ($urandom_range(0, 3) != 0);
            v.aa = 3'($urandom_range(0, 7));
            v.ad = 16'($urandom());
            v.fa = 3'($urandom_range(0, 7));
            run_cycle(v, 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
